// File: rtl/spi_reg_pkg.sv
// Purpose : shared types and constants for the SPI register bridge.
// Latency : n/a (package).
// Backpressure: n/a; the SPI byte stream has no flow control.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        CMD  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam int          CMD_WR_BIT          = 7;
    localparam int          ADDR_W              = 7;
    localparam logic [7:0]  STATUS_IDLE_DEFAULT = 8'h00;

    // True when address a maps onto an implemented register.
    function automatic logic addr_in_range(logic [ADDR_W-1:0] a, int unsigned n);
        return 32'(a) < n;
    endfunction

endpackage

// File: rtl/spi_reg_file.sv
// Purpose : NUM_REGS x 8-bit control register array, one write port, one combinational read port.
// Latency : write visible on reg_q/rd_data the cycle after we; read is combinational.
// Backpressure: none; every write request is accepted.
// Ports   : clk/reset; we/wr_addr/wr_data write port; rd_addr/rd_data read port
//           (out-of-range reads return 8'h00); reg_q flattened contents, reg n at [8n+7:8n].
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [7:0]            rd_data,
    output logic [NUM_REGS*8-1:0] reg_q
);

    logic [NUM_REGS*8-1:0] regs;

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= {NUM_REGS{RESET_VAL}};
        end else if (we) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    regs[8*i +: 8] <= wr_data;
                end
            end
        end
    end

    // Addresses with no backing register fall through to 8'h00.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs[8*i +: 8];
            end
        end
    end

    assign reg_q = regs;

endmodule

// File: rtl/spi_reg_bridge.sv
// Purpose : decodes SPI slave byte stream {wr,addr7} + data bytes into register reads/writes.
// Latency : tx_byte, reg_q, wr_stb/wr_addr/wr_data all update the cycle after rx_dv.
// Backpressure: none; every rx_dv byte is consumed in the cycle it arrives.
// Ports   : clk, reset (sync, active-high); spi_cs (active low, synchronised), rx_dv/rx_byte
//           from slave; tx_byte to slave; status_in returned during the command byte;
//           err (sticky, out-of-range access) / err_clr; wr_stb/wr_addr/wr_data write strobe;
//           reg_q flattened registers.
// Build   : define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after each data byte.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    output logic [7:0]            tx_byte,
    input  logic [7:0]            status_in,
    input  logic                  err_clr,
    output logic                  err,
    output logic                  wr_stb,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_REGS*8-1:0] reg_q
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_wr;
    logic              rf_we;
    logic              err_set;

    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign cmd_wr   = rx_byte[CMD_WR_BIT];

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    // 7-bit add wraps 127 -> 0 naturally.
    assign next_addr = addr + ADDR_W'(1);
`else
    assign next_addr = addr;
`endif

    // Command byte reads the addressed register; data bytes prefetch the
    // address the next MISO byte will come from.
    assign rd_addr = (state == CMD) ? cmd_addr : next_addr;

    assign rf_we = (state == DATA) && rx_dv && wr && addr_in_range(addr, NUM_REGS);

    always_comb begin
        err_set = 1'b0;
        if (rx_dv) begin
            if (state == CMD) begin
                err_set = !cmd_wr && !addr_in_range(cmd_addr, NUM_REGS);
            end else if (state == DATA) begin
                err_set = wr ? !addr_in_range(addr, NUM_REGS)
                             : !addr_in_range(next_addr, NUM_REGS);
            end
        end
    end

    spi_reg_file #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .wr_addr (addr),
        .wr_data (rx_byte),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .reg_q   (reg_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SYNC;
            addr    <= '0;
            wr      <= 1'b0;
            tx_byte <= STATUS_IDLE_DEFAULT;
            err     <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
        end else begin
            wr_stb <= 1'b0;

            // A new error in the same cycle as a clear must survive.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                // Coming out of reset mid-frame: wait for a clean frame boundary.
                SYNC: begin
                    if (spi_cs) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    tx_byte <= status_in;
                    if (!spi_cs) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (rx_dv) begin
                        addr  <= cmd_addr;
                        wr    <= cmd_wr;
                        state <= DATA;
                        if (!cmd_wr) begin
                            tx_byte <= rd_data;
                        end
                    end
                    if (spi_cs) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    // A byte landing with the cs release is still honoured.
                    if (rx_dv) begin
                        if (wr) begin
                            if (rf_we) begin
                                wr_stb  <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= rx_byte;
                            end
                        end else begin
                            tx_byte <= rd_data;
                        end
                        addr <= next_addr;
                    end
                    if (spi_cs) begin
                        state <= IDLE;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;

    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_cs;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_byte;
    logic [7:0]    status_in;
    logic          err_clr;
    logic          err;
    logic          wr_stb;
    logic [6:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [NR*8-1:0] reg_q;

    int checks   = 0;
    int failures = 0;
    int stb_cnt  = 0;
    int stb_base;

    spi_reg_bridge #(.NUM_REGS(NR), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .status_in (status_in),
        .err_clr   (err_clr),
        .err       (err),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_q     (reg_q)
    );

    always #5 clk = ~clk;

    // Counts cycles with wr_stb high, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) stb_cnt++;
    end

    function automatic logic [7:0] reg_at(int n);
        return reg_q[8*n +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
        cyc(3);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs = 1'b0;
        cyc(2);
    endtask

    task automatic cs_high();
        @(negedge clk);
        spi_cs = 1'b1;
        cyc(2);
    endtask

    initial begin
        reset     = 1'b1;
        spi_cs    = 1'b0;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        status_in = 8'h77;
        err_clr   = 1'b0;
        cyc(3);

        // Reset values
        check("rst_tx", 32'(tx_byte), 32'h00);
        check("rst_err", 32'(err), 32'h0);
        check("rst_stb", 32'(wr_stb), 32'h0);
        check("rst_waddr", 32'(wr_addr), 32'h0);
        check("rst_wdata", 32'(wr_data), 32'h0);
        check("rst_regq_zero", 32'(reg_q == '0), 32'h1);

        // 1: reset released with cs low -> frame ignored, stays in SYNC
        reset = 1'b0;
        stb_base = stb_cnt;
        send_byte(8'h81);
        send_byte(8'h5A);
        check("t1_no_stb", 32'(stb_cnt - stb_base), 32'h0);
        check("t1_reg1", 32'(reg_at(1)), 32'h00);
        check("t1_tx_sync", 32'(tx_byte), 32'h00);
        cs_high();
        check("t1_tx_idle", 32'(tx_byte), 32'h77);

        // 2: single write 0x83, 0xC1 with exact latency
        cs_low();
        send_byte(8'h83);
        stb_base = stb_cnt;
        @(negedge clk);
        rx_byte = 8'hC1;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
        check("t2_stb_hi", 32'(wr_stb), 32'h1);
        check("t2_waddr", 32'(wr_addr), 32'h3);
        check("t2_wdata", 32'(wr_data), 32'hC1);
        check("t2_reg3", 32'(reg_q[31:24]), 32'hC1);
        @(negedge clk);
        check("t2_stb_lo", 32'(wr_stb), 32'h0);
        check("t2_stb_cnt", 32'(stb_cnt - stb_base), 32'h1);
        cs_high();

        // 3: read frame returns status then register
        status_in = 8'hA5;
        cyc(1);
        cs_low();
        check("t3_miso0", 32'(tx_byte), 32'hA5);
        send_byte(8'h03);
        check("t3_miso1", 32'(tx_byte), 32'hC1);
        send_byte(8'h00);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        check("t3_miso2", 32'(tx_byte), 32'h00);
`else
        check("t3_miso2", 32'(tx_byte), 32'hC1);
`endif
        check("t3_err", 32'(err), 32'h0);
        cs_high();

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        // 4: burst crossing the end of the register space
        stb_base = stb_cnt;
        cs_low();
        send_byte(8'h8E);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        cs_high();
        check("t4_reg14", 32'(reg_at(14)), 32'h11);
        check("t4_reg15", 32'(reg_at(15)), 32'h22);
        check("t4_err", 32'(err), 32'h1);
        check("t4_stb_cnt", 32'(stb_cnt - stb_base), 32'h2);
`else
        // 5: fixed address, both bytes hit reg 2
        stb_base = stb_cnt;
        cs_low();
        send_byte(8'h82);
        send_byte(8'h11);
        check("t5_waddr0", 32'(wr_addr), 32'h2);
        check("t5_wdata0", 32'(wr_data), 32'h11);
        send_byte(8'h22);
        cs_high();
        check("t5_waddr1", 32'(wr_addr), 32'h2);
        check("t5_reg2", 32'(reg_at(2)), 32'h22);
        check("t5_reg3_kept", 32'(reg_at(3)), 32'hC1);
        check("t5_stb_cnt", 32'(stb_cnt - stb_base), 32'h2);
        check("t5_err", 32'(err), 32'h0);
`endif

        // Clear any error
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_err", 32'(err), 32'h0);

        // 6a: cs released after command only -> nothing written
        stb_base = stb_cnt;
        cs_low();
        send_byte(8'h85);
        cs_high();
        check("t6_no_stb", 32'(stb_cnt - stb_base), 32'h0);
        check("t6_reg5", 32'(reg_at(5)), 32'h00);

        // 6b: out-of-range write with err_clr in the same cycle -> set wins
        cs_low();
        send_byte(8'h90);
        @(negedge clk);
        rx_byte = 8'h44;
        rx_dv   = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
        err_clr = 1'b0;
        check("t6_err_set_wins", 32'(err), 32'h1);
        check("t6_oor_no_stb", 32'(stb_cnt - stb_base), 32'h0);
        cs_high();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t6_err_cleared", 32'(err), 32'h0);

        // rx_dv coinciding with cs rising: byte committed, then IDLE ignores more bytes
        status_in = 8'h5C;
        stb_base = stb_cnt;
        cs_low();
        send_byte(8'h86);
        @(negedge clk);
        rx_byte = 8'h3C;
        rx_dv   = 1'b1;
        spi_cs  = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
        check("cs_edge_reg6", 32'(reg_at(6)), 32'h3C);
        check("cs_edge_stb", 32'(wr_stb), 32'h1);
        send_byte(8'h99);
        check("idle_ignore_stb", 32'(stb_cnt - stb_base), 32'h1);
        check("idle_tx_status", 32'(tx_byte), 32'h5C);

        // Out-of-range read returns zero and flags err
        cs_low();
        send_byte(8'h7F);
        check("oor_rd_tx", 32'(tx_byte), 32'h00);
        check("oor_rd_err", 32'(err), 32'h1);
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
